// File: rtl/pim_mac_engine.sv
// Sequential MAC responder for one PIM slot: takes one A/B sub-chunk pair, computes the
// CHUNK_SIZE x CHUNK_SIZE partial product one multiply-accumulate per clock, then pulses result_valid.
module pim_mac_engine #(
  parameter int ID                = 0,
  parameter int WIDTH             = 32,
  parameter int CHUNK_SIZE        = 2,
  parameter int PIM_UNIT_CAPACITY = 2
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic                                                 valid,
  input  logic [CHUNK_SIZE-1:0][PIM_UNIT_CAPACITY-1:0][WIDTH-1:0] matrixA,
  input  logic [PIM_UNIT_CAPACITY-1:0][CHUNK_SIZE-1:0][WIDTH-1:0] matrixB,
  output logic [CHUNK_SIZE*CHUNK_SIZE-1:0][WIDTH-1:0]          result,
  output logic                                                 result_valid,
  output logic                                                 busy,
  output logic [1:0]                                           state_dbg,
  output logic [31:0]                                          slot_id
);

  localparam int NE = CHUNK_SIZE * CHUNK_SIZE;
  localparam int RW = (CHUNK_SIZE > 1) ? $clog2(CHUNK_SIZE) : 1;
  localparam int KW = (PIM_UNIT_CAPACITY > 1) ? $clog2(PIM_UNIT_CAPACITY) : 1;
  localparam int IW = (NE > 1) ? $clog2(NE) : 1;
  localparam logic [RW-1:0] CMAX = RW'(CHUNK_SIZE - 1);
  localparam logic [KW-1:0] KMAX = KW'(PIM_UNIT_CAPACITY - 1);
  localparam logic [IW-1:0] IMAX = IW'(NE - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, COMPUTE = 2'd1, DONE = 2'd2} state_t;

  state_t state_q, state_d;

  logic [CHUNK_SIZE-1:0][PIM_UNIT_CAPACITY-1:0][WIDTH-1:0] a_q;
  logic [PIM_UNIT_CAPACITY-1:0][CHUNK_SIZE-1:0][WIDTH-1:0] b_q;
  logic [NE-1:0][WIDTH-1:0] work;
  logic [WIDTH-1:0]         acc;
  logic [WIDTH-1:0]         prod;
  logic [RW-1:0]            r;
  logic [RW-1:0]            c;
  logic [KW-1:0]            k;
  logic [IW-1:0]            idx;
  logic                     last_mac;

  // Handshake: a request is a single-cycle valid with operands on the same edge. It is
  // accepted only when busy=0 (IDLE); while busy=1 valid is dropped, never queued.
  // result_valid is a one-cycle pulse with no back-pressure; result holds until the next pulse.

  assign prod      = a_q[r][k] * b_q[k][c];
  assign last_mac  = (k == KMAX) && (idx == IMAX);
  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;
  assign slot_id   = ID;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (valid) state_d = COMPUTE;
      COMPUTE: if (last_mac) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q          <= '0;
      b_q          <= '0;
      work         <= '0;
      acc          <= '0;
      r            <= '0;
      c            <= '0;
      k            <= '0;
      idx          <= '0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= (state_q == DONE);
      case (state_q)
        IDLE: begin
          if (valid) begin
            a_q <= matrixA;
            b_q <= matrixB;
            acc <= '0;
            r   <= '0;
            c   <= '0;
            k   <= '0;
            idx <= '0;
          end
        end
        COMPUTE: begin
          // k innermost, then c, then r: idx tracks r*CHUNK_SIZE+c directly
          if (k == KMAX) begin
            work[idx] <= acc + prod;
            acc       <= '0;
            k         <= '0;
            idx       <= idx + 1'b1;
            if (c == CMAX) begin
              c <= '0;
              r <= r + 1'b1;
            end else begin
              c <= c + 1'b1;
            end
          end else begin
            acc <= acc + prod;
            k   <= k + 1'b1;
          end
        end
        DONE: result <= work;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pim_mac_engine.sv
// Scoreboard bench for pim_mac_engine: a driver pushes model results and expected pulse
// cycles into queues; a negedge monitor pops and compares on every result_valid pulse.
module tb_pim_mac_engine;

  localparam int W   = 32;
  localparam int CS  = 2;
  localparam int CAP = 2;
  localparam int RB  = CS * CS * W;

  typedef logic [CS-1:0][CAP-1:0][W-1:0] mat_a;
  typedef logic [CAP-1:0][CS-1:0][W-1:0] mat_b;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         valid = 1'b0;
  mat_a         matrix_a = '0;
  mat_b         matrix_b = '0;
  logic [CS*CS-1:0][W-1:0] result;
  logic         result_valid;
  logic         busy;
  logic [1:0]   state_dbg;
  logic [31:0]  slot_id;

  pim_mac_engine #(.ID(0), .WIDTH(W), .CHUNK_SIZE(CS), .PIM_UNIT_CAPACITY(CAP)) dut (
    .clk(clk), .rst(rst), .valid(valid),
    .matrixA(matrix_a), .matrixB(matrix_b),
    .result(result), .result_valid(result_valid), .busy(busy),
    .state_dbg(state_dbg), .slot_id(slot_id)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  logic [RB-1:0] exp_q[$];
  int            exp_t_q[$];
  logic [RB-1:0] last_exp = '0;
  int            bstart = -100;
  int            checks = 0;
  int            errors = 0;
  bit            mon_on = 1'b0;

  task automatic check(input string name, input logic [RB-1:0] act, input logic [RB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference model: C[r][c] = sum_k A[r][k]*B[k][c] mod 2**W, row-major
  function automatic logic [RB-1:0] model(input mat_a a, input mat_b b);
    logic [RB-1:0] res;
    logic [W-1:0]  sum;
    res = '0;
    for (int rr = 0; rr < CS; rr++)
      for (int cc = 0; cc < CS; cc++) begin
        sum = '0;
        for (int kk = 0; kk < CAP; kk++) sum += a[rr][kk] * b[kk][cc];
        res[(rr*CS+cc)*W +: W] = sum;
      end
    return res;
  endfunction

  // monitor
  always @(negedge clk) begin
    if (mon_on && !rst) begin
      check("busy", RB'(busy), RB'((cyc >= bstart) && (cyc <= bstart + 8)));
      if (result_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", RB'(1), RB'(0));
        end else begin
          last_exp = exp_q.pop_front();
          check("result", result, last_exp);
          check("pulse_cycle", RB'(cyc), RB'(exp_t_q.pop_front()));
        end
      end else begin
        check("result_hold", result, last_exp);
      end
    end
  end

  // driver tasks (called just after a negedge)
  task automatic send(input mat_a a, input mat_b b, input bit push);
    valid    = 1'b1;
    matrix_a = a;
    matrix_b = b;
    if (push) begin
      exp_q.push_back(model(a, b));
      exp_t_q.push_back(cyc + 10);
      bstart = cyc + 1;
    end
    @(negedge clk);
    valid    = 1'b0;
    matrix_a = '0;
    matrix_b = '0;
  endtask

  task automatic wait_pulse();
    int n;
    n = 0;
    @(negedge clk);
    while (!result_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!result_valid) check("pulse_timeout", RB'(0), RB'(1));
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("drain", RB'(exp_q.size()), RB'(0));
    @(negedge clk);
  endtask

  function automatic mat_a rand_a();
    mat_a a;
    for (int i = 0; i < CS; i++)
      for (int j = 0; j < CAP; j++)
        a[i][j] = ($urandom_range(0, 1) == 1) ? $urandom : W'($urandom_range(0, 15));
    return a;
  endfunction

  function automatic mat_b rand_b();
    mat_b b;
    for (int i = 0; i < CAP; i++)
      for (int j = 0; j < CS; j++)
        b[i][j] = ($urandom_range(0, 1) == 1) ? $urandom : W'($urandom_range(0, 15));
    return b;
  endfunction

  initial begin
    mat_a a;
    mat_b b;
    logic [RB-1:0] basic;

    // reset state
    #1;
    check("reset_result", result, '0);
    check("reset_valid", RB'(result_valid), RB'(0));
    check("reset_busy", RB'(busy), RB'(0));
    check("reset_state", RB'(state_dbg), RB'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mon_on = 1'b1;

    // basic
    a[0][0] = 1; a[0][1] = 2; a[1][0] = 3; a[1][1] = 4;
    b[0][0] = 5; b[0][1] = 6; b[1][0] = 7; b[1][1] = 8;
    send(a, b, 1'b1);
    wait_drain();
    basic = {32'd50, 32'd43, 32'd22, 32'd19};
    check("basic_const", result, basic);

    // zeros with hold of previous result through COMPUTE
    send('0, '0, 1'b1);
    wait_drain();

    // wrap
    for (int i = 0; i < CS; i++)
      for (int j = 0; j < CAP; j++) begin
        a[i][j] = 32'hFFFF_FFFF;
        b[j][i] = 32'd1;
      end
    send(a, b, 1'b1);
    wait_drain();
    check("wrap_const", result, {CS*CS{32'hFFFF_FFFE}});

    // back-to-back: second request issued in the pulse cycle
    send(rand_a(), rand_b(), 1'b1);
    wait_pulse();
    send(rand_a(), rand_b(), 1'b1);
    wait_drain();

    // garbage valid pulses while busy are ignored
    send(rand_a(), rand_b(), 1'b1);
    @(negedge clk);
    send(rand_a(), rand_b(), 1'b0);
    repeat (2) @(negedge clk);
    send(rand_a(), rand_b(), 1'b0);
    wait_drain();

    // asynchronous reset between edges during COMPUTE
    send(rand_a(), rand_b(), 1'b1);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    exp_q.delete();
    exp_t_q.delete();
    last_exp = '0;
    bstart = -100;
    #1;
    check("rst_result", result, '0);
    check("rst_valid", RB'(result_valid), RB'(0));
    check("rst_busy", RB'(busy), RB'(0));
    check("rst_state", RB'(state_dbg), RB'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(a, b, 1'b1);
    wait_drain();

    // randomized jobs with mixed gaps, back-to-back and ignored requests
    for (int it = 0; it < 24; it++) begin
      send(rand_a(), rand_b(), 1'b1);
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        send(rand_a(), rand_b(), 1'b0);
      end
      wait_pulse();
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
